// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor and branch_decision:
// 2-bit counter states, BHT reset value and branch func3 encodings.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BHT_RESET_VAL = WNT;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_func3_e;

    // The upper counter bit is the taken/not-taken decision.
    function automatic logic predict_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit saturating counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state
);

    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != ST) begin
                next_state = state + 2'd1;
            end
        end else begin
            if (state != SNT) begin
                next_state = state - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Untagged 2-bit BHT predictor with registered mispredict redirect/flush.
// Define BP_PERF_CNT_EN to add resolved-branch and mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_if_pc,
    output logic              o_pred_taken,
    input  logic              i_stall,
    input  logic              i_ex_valid,
    input  logic              i_ex_is_branch,
    input  logic [ADDR_W-1:0] i_ex_pc,
    input  logic              i_ex_pred_taken,
    input  logic              i_ex_branch,
    input  logic [ADDR_W-1:0] i_ex_target,
    output logic              o_redirect,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic              o_flush,
    output logic [31:0]       o_br_count,
    output logic [31:0]       o_mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic [1:0]        bht_vec [BHT_ENTRIES];
    logic [1:0]        ctr_next;
    logic              res;
    logic              mis;
    logic              redirect_reg;
    logic [ADDR_W-1:0] redirect_pc_reg;
    logic [ADDR_W-1:0] redirect_pc_next;
    logic              unused_pc_bits;

    assign if_idx = i_if_pc[IDX_W+1:2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{i_if_pc, i_ex_pc};

    assign res = i_ex_valid & i_ex_is_branch & ~i_stall;
    assign mis = res & (i_ex_pred_taken != i_ex_branch);

    // Fetch sees the pre-update counter when both ports hit the same entry.
    assign o_pred_taken = predict_taken(bht_vec[if_idx]);

    sat_counter2 u_sat_counter2 (
        .state      (bht_vec[ex_idx]),
        .taken      (i_ex_branch),
        .next_state (ctr_next)
    );

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] ctr_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ctr_reg <= BHT_RESET_VAL;
                end else if (res && (ex_idx == IDX_W'(gi))) begin
                    ctr_reg <= ctr_next;
                end
            end

            assign bht_vec[gi] = ctr_reg;
        end
    endgenerate

    assign redirect_pc_next = i_ex_branch ? i_ex_target : (i_ex_pc + ADDR_W'(4));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            redirect_reg <= mis;
            if (mis) begin
                redirect_pc_reg <= redirect_pc_next;
            end
        end
    end

    assign o_redirect    = redirect_reg;
    assign o_flush       = redirect_reg;
    assign o_redirect_pc = redirect_pc_reg;

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_count_reg;
    logic [31:0] mispred_count_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_count_reg      <= 32'd0;
            mispred_count_reg <= 32'd0;
        end else begin
            if (res) begin
                br_count_reg <= br_count_reg + 32'd1;
            end
            if (mis) begin
                mispred_count_reg <= mispred_count_reg + 32'd1;
            end
        end
    end

    assign o_br_count      = br_count_reg;
    assign o_mispred_count = mispred_count_reg;
`else
    assign o_br_count      = 32'd0;
    assign o_mispred_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed plan plus randomized
// traffic checked against an integer-counter reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic        i_stall;
    logic        i_ex_valid;
    logic        i_ex_is_branch;
    logic [31:0] i_ex_pc;
    logic        i_ex_pred_taken;
    logic        i_ex_branch;
    logic [31:0] i_ex_target;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_flush;
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    branch_predictor #(.ADDR_W(32), .BHT_ENTRIES(ENTRIES)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_if_pc         (i_if_pc),
        .o_pred_taken    (o_pred_taken),
        .i_stall         (i_stall),
        .i_ex_valid      (i_ex_valid),
        .i_ex_is_branch  (i_ex_is_branch),
        .i_ex_pc         (i_ex_pc),
        .i_ex_pred_taken (i_ex_pred_taken),
        .i_ex_branch     (i_ex_branch),
        .i_ex_target     (i_ex_target),
        .o_redirect      (o_redirect),
        .o_redirect_pc   (o_redirect_pc),
        .o_flush         (o_flush),
        .o_br_count      (o_br_count),
        .o_mispred_count (o_mispred_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each BHT entry is an integer 0..3, taken means >= 2.
    int          m_ctr [ENTRIES];
    logic        m_redir;
    logic [31:0] m_rpc;
    int          m_br;
    int          m_mis;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_redir = 1'b0;
        m_rpc   = 32'd0;
        m_br    = 0;
        m_mis   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".redirect"}, {31'd0, o_redirect}, {31'd0, m_redir});
        check({tag, ".flush"}, {31'd0, o_flush}, {31'd0, m_redir});
        check({tag, ".redirect_pc"}, o_redirect_pc, m_rpc);
`ifdef BP_PERF_CNT_EN
        check({tag, ".br_count"}, o_br_count, m_br);
        check({tag, ".mispred_count"}, o_mispred_count, m_mis);
`else
        check({tag, ".br_count"}, o_br_count, 32'd0);
        check({tag, ".mispred_count"}, o_mispred_count, 32'd0);
`endif
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the result.
    task automatic step(input string tag, input logic v, input logic isbr,
                        input logic [31:0] pc, input logic pred, input logic br,
                        input logic [31:0] tgt, input logic stall,
                        input logic [31:0] if_pc);
        logic res;
        logic mis;
        int   k;
        i_ex_valid      = v;
        i_ex_is_branch  = isbr;
        i_ex_pc         = pc;
        i_ex_pred_taken = pred;
        i_ex_branch     = br;
        i_ex_target     = tgt;
        i_stall         = stall;
        i_if_pc         = if_pc;
        #1;
        check({tag, ".pred"}, {31'd0, o_pred_taken}, (m_ctr[midx(if_pc)] >= 2) ? 32'd1 : 32'd0);
        @(posedge i_clk);
        res = v && isbr && !stall;
        mis = res && (pred != br);
        if (res) begin
            k = midx(pc);
            m_ctr[k] = br ? ((m_ctr[k] == 3) ? 3 : m_ctr[k] + 1)
                          : ((m_ctr[k] == 0) ? 0 : m_ctr[k] - 1);
            m_br++;
        end
        m_redir = mis;
        if (mis) begin
            m_rpc = br ? tgt : pc + 32'd4;
            m_mis++;
        end
        @(negedge i_clk);
        check_outputs(tag);
        $display("%s: v=%0d br=%0d stall=%0d pc=0x%0h pred=%0d taken=%0d -> redirect=%0d pc=0x%0h",
                 tag, v, isbr, stall, pc, pred, br, o_redirect, o_redirect_pc);
    endtask

    initial begin
        i_rst = 1'b1;
        i_if_pc = 32'd0; i_stall = 1'b0; i_ex_valid = 1'b0; i_ex_is_branch = 1'b0;
        i_ex_pc = 32'd0; i_ex_pred_taken = 1'b0; i_ex_branch = 1'b0; i_ex_target = 32'd0;
        model_reset();
        repeat (2) @(negedge i_clk);
        check_outputs("reset");
        i_rst = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            i_if_pc = i * 4;
            #1;
            check("reset_bht_pred", {31'd0, o_pred_taken}, 32'd0);
        end
        @(negedge i_clk);

        // Taken mispredict at 0x40, then a fetch of 0x40 predicts taken.
        step("mis_taken", 1, 1, 32'h40, 0, 1, 32'h100, 0, 32'h40);
        step("pulse_end", 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h40);
        // Train to strong-taken, then a not-taken mispredict.
        for (int i = 0; i < 3; i++) step("train_t", 1, 1, 32'h40, 1, 1, 32'h100, 0, 32'h40);
        step("mis_nt", 1, 1, 32'h40, 1, 0, 32'h100, 0, 32'h40);
        step("after_nt", 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h40);
        // Correct prediction saturates at 11, not-taken saturates at 00.
        step("sat_hi", 1, 1, 32'h40, 1, 1, 32'h100, 0, 32'h40);
        step("sat_hi2", 1, 1, 32'h40, 1, 1, 32'h100, 0, 32'h40);
        for (int i = 0; i < 3; i++) step("sat_lo", 1, 1, 32'h80, 0, 0, 32'h200, 0, 32'h80);
        // Non-branch and invalid slots are ignored.
        step("nonbranch", 1, 0, 32'h80, 1, 0, 32'h300, 0, 32'h80);
        step("invalid", 0, 1, 32'h80, 1, 0, 32'h300, 0, 32'h80);
        // Stalled mispredict is ignored, then re-presented unstalled.
        step("stalled", 1, 1, 32'hC0, 0, 1, 32'h400, 1, 32'hC0);
        step("unstalled", 1, 1, 32'hC0, 0, 1, 32'h400, 0, 32'hC0);
        // Back-to-back mispredicts, each with its own redirect PC.
        step("b2b_a", 1, 1, 32'h104, 0, 1, 32'h500, 0, 32'h104);
        step("b2b_b", 1, 1, 32'h108, 1, 0, 32'h600, 0, 32'h108);
        // Fall-through PC wraps at the top of the address space.
        step("wrap", 1, 1, 32'hFFFF_FFFC, 1, 0, 32'h700, 0, 32'hFFFF_FFFC);
        step("idle", 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

        // Randomized traffic over a small PC pool so entries alias.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(0, 7), 8'h0} | ($urandom_range(0, 15) << 2);
            step("rand", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), rpc,
                 1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 255) << 2));
        end

        // Asynchronous reset while a redirect pulse is high.
        step("pre_rst", 1, 1, 32'h40, 0, 1, 32'h900, 0, 32'h40);
        check("pre_rst.pulse_high", {31'd0, o_redirect}, 32'd1);
        i_rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        i_if_pc = 32'h40;
        #1;
        check("async_rst.pred", {31'd0, o_pred_taken}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step("post_rst", 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
